// File: rtl/oserdes_feeder_pkg.sv
// Shared types and constants for the O_SERDES word feeder.
// PRBS7 constants are consumed only when OSERDES_FEEDER_PRBS_EN is defined.
package oserdes_feeder_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        TRAIN     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned UF_CNT_W = 8;

    localparam logic [6:0] PRBS7_TAPS = 7'h60;  // x^7 + x^6 + 1
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    localparam logic [3:0] DEF_IDLE_WORD     = 4'b0000;
    localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b1010;

    // One Fibonacci step; the bit leaving s[6] is the serial output.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction

endpackage

// File: rtl/oserdes_feeder_fifo.sv
// Synchronous word FIFO with flush; DEPTH must be a power of two >= 2.
module oserdes_feeder_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Flush has priority over any push/pop in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/oserdes_word_feeder.sv
// Fabric-side feeder for a 4:1 O_SERDES: lock settle, training burst, then FIFO words per load slot.
// Define OSERDES_FEEDER_PRBS_EN to train with PRBS7 chunks instead of TRAIN_PATTERN.
module oserdes_word_feeder
    import oserdes_feeder_pkg::*;
#(
    parameter int unsigned       WIDTH         = 4,
    parameter int unsigned       FIFO_DEPTH    = 4,
    parameter int unsigned       LOAD_INTERVAL = 1,
    parameter int unsigned       LOCK_SETTLE   = 8,
    parameter int unsigned       TRAIN_WORDS   = 16,
    parameter logic [WIDTH-1:0]  TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
    parameter logic [WIDTH-1:0]  IDLE_WORD     = WIDTH'(DEF_IDLE_WORD)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pll_lock,
    input  logic [WIDTH-1:0]    i_data_in,
    input  logic                i_data_valid,
    output logic                o_data_ready,
    output logic [WIDTH-1:0]    o_d_out,
    output logic                o_load_word,
    output logic                o_oe,
    output logic                o_train_done,
    output logic [UF_CNT_W-1:0] o_underflow_cnt
);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SLOT_W   = $clog2(LOAD_INTERVAL + 1);
    localparam int unsigned SETTLE_W = $clog2(LOCK_SETTLE + 1);
    localparam int unsigned TRAIN_W  = $clog2(TRAIN_WORDS + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [TRAIN_W-1:0]  r_train_cnt;
    logic [WIDTH-1:0]    r_d_out;
    logic                r_load_word;
    logic                r_oe;
    logic                r_train_done;
    logic [UF_CNT_W-1:0] r_uf_cnt;

    logic                w_active;
    logic                w_next_active;
    logic                w_slot;
    logic                w_ready;
    logic                w_pop;
    logic                w_uf_inc;
    logic                w_load_nxt;
    logic [WIDTH-1:0]    w_d_out_nxt;
    logic [WIDTH-1:0]    w_train_word;
    logic [WIDTH-1:0]    w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;

    assign w_active      = (r_state == TRAIN) || (r_state == RUN);
    assign w_next_active = (w_next_state == TRAIN) || (w_next_state == RUN);
    assign w_slot        = w_active && (r_slot_cnt == '0);
    assign w_fifo_empty  = (w_fifo_count == '0);
    assign w_ready       = w_active && !w_fifo_full;

    oserdes_feeder_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (!i_pll_lock),
        .i_push  (i_data_valid && w_ready),
        .i_pop   (w_pop),
        .i_data  (i_data_in),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

`ifdef OSERDES_FEEDER_PRBS_EN
    logic [6:0]       r_lfsr;
    logic [6:0]       w_lfsr_nxt;
    logic [WIDTH-1:0] w_prbs_word;

    // Advance WIDTH bits per slot; first bit out lands in the MSB.
    always_comb begin
        w_lfsr_nxt  = r_lfsr;
        w_prbs_word = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_prbs_word[i] = w_lfsr_nxt[6];
            w_lfsr_nxt     = prbs7_step(w_lfsr_nxt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != TRAIN)) begin
            r_lfsr <= PRBS7_SEED;
        end else if (w_slot) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign w_train_word = w_prbs_word;
`else
    assign w_train_word = TRAIN_PATTERN;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lock loss overrides every state.
    always_comb begin
        w_next_state = r_state;
        if (!i_pll_lock) begin
            w_next_state = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: w_next_state = SETTLE;
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_W'(LOCK_SETTLE - 1)) begin
                        w_next_state = TRAIN;
                    end
                end
                TRAIN: begin
                    if (w_slot && (r_train_cnt == TRAIN_W'(TRAIN_WORDS - 1))) begin
                        w_next_state = RUN;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_load_nxt  = 1'b0;
        w_d_out_nxt = r_d_out;
        w_pop       = 1'b0;
        w_uf_inc    = 1'b0;
        if (!i_pll_lock) begin
            w_d_out_nxt = IDLE_WORD;
        end else if (w_slot) begin
            w_load_nxt = 1'b1;
            if (r_state == TRAIN) begin
                w_d_out_nxt = w_train_word;
            end else if (!w_fifo_empty) begin
                w_pop       = 1'b1;
                w_d_out_nxt = w_fifo_data;
            end else begin
                w_d_out_nxt = IDLE_WORD;
                w_uf_inc    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot_cnt   <= '0;
            r_settle_cnt <= '0;
            r_train_cnt  <= '0;
            r_d_out      <= IDLE_WORD;
            r_load_word  <= 1'b0;
            r_oe         <= 1'b0;
            r_train_done <= 1'b0;
            r_uf_cnt     <= '0;
        end else begin
            r_d_out      <= w_d_out_nxt;
            r_load_word  <= w_load_nxt;
            r_oe         <= i_pll_lock && w_active;
            r_train_done <= (w_next_state == RUN);

            if (w_active && w_next_active) begin
                r_slot_cnt <= (r_slot_cnt == SLOT_W'(LOAD_INTERVAL - 1)) ? '0 : r_slot_cnt + SLOT_W'(1);
            end else begin
                r_slot_cnt <= '0;
            end

            if ((r_state == SETTLE) && (w_next_state == SETTLE)) begin
                r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            if (r_state != TRAIN) begin
                r_train_cnt <= '0;
            end else if (w_slot) begin
                r_train_cnt <= r_train_cnt + TRAIN_W'(1);
            end

            if (w_uf_inc && (r_uf_cnt != '1)) begin
                r_uf_cnt <= r_uf_cnt + UF_CNT_W'(1);
            end
        end
    end

    assign o_data_ready    = w_ready;
    assign o_d_out         = r_d_out;
    assign o_load_word     = r_load_word;
    assign o_oe            = r_oe;
    assign o_train_done    = r_train_done;
    assign o_underflow_cnt = r_uf_cnt;

endmodule
